// File: rtl/sim_pcie_axis_model.sv
// Simulation stand-in for a PCIe endpoint core: link bring-up, AXIS RX packet source, TX sink, config reads.
// Optional interrupt handshake model enabled with `define SIM_PCIE_INTR_EN.
module sim_pcie_axis_model #(
  parameter int           DATA_WIDTH    = 32,
  parameter int           RESET_CYCLES  = 16,
  parameter int           LINKUP_CYCLES = 16,
  parameter logic [127:0] PKT_LEN_MAP   = 128'h0200_0080,
  parameter int           TX_THROTTLE   = 0
) (
  input  logic                    sys_clk_p,
  input  logic                    sys_reset,
  output logic                    user_reset_out,
  output logic                    user_lnk_up,
  output logic                    user_enable_comm,
  input  logic                    i_rx_start,
  input  logic [2:0]              i_rx_func,
  output logic [DATA_WIDTH-1:0]   m_axis_rx_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_rx_tkeep,
  output logic                    m_axis_rx_tlast,
  output logic                    m_axis_rx_tvalid,
  input  logic                    m_axis_rx_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tx_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tx_tkeep,
  input  logic                    s_axis_tx_tlast,
  input  logic                    s_axis_tx_tvalid,
  output logic                    s_axis_tx_tready,
  output logic [31:0]             o_tx_beat_count,
  output logic [15:0]             o_tx_pkt_count,
  input  logic [9:0]              cfg_dwaddr,
  input  logic                    cfg_rd_en,
  output logic [31:0]             cfg_do,
  output logic                    cfg_rd_wr_done,
  input  logic                    cfg_interrupt,
  output logic                    cfg_interrupt_rdy
);

  localparam int          KW        = DATA_WIDTH / 8;
  localparam logic [31:0] RESET_END = 32'(RESET_CYCLES);
  localparam logic [31:0] LINK_END  = 32'(RESET_CYCLES + LINKUP_CYCLES);
  localparam logic [31:0] COMM_AT   = LINK_END + 32'd15;
  localparam logic [31:0] SEQ_END   = COMM_AT + 32'd1;

  // One saturating counter drives the whole bring-up sequence, so enable_comm can only fire once.
  logic [31:0] seq_cnt;

  always_ff @(posedge sys_clk_p or posedge sys_reset) begin
    if (sys_reset)
      seq_cnt <= '0;
    else if (seq_cnt != SEQ_END)
      seq_cnt <= seq_cnt + 32'd1;
  end

  assign user_reset_out   = sys_reset || (seq_cnt < RESET_END);
  assign user_lnk_up      = !sys_reset && (seq_cnt >= LINK_END);
  assign user_enable_comm = !sys_reset && (seq_cnt == COMM_AT);

  typedef enum logic [0:0] {RX_IDLE, RX_SEND} rx_state_t;

  rx_state_t   state, state_next;
  logic [15:0] beat, beat_next;
  logic [2:0]  rx_func, rx_func_next;
  logic [15:0] sel_len, cur_len;
  logic        last_beat;

  assign sel_len   = PKT_LEN_MAP[{i_rx_func, 4'b0000} +: 16];
  assign cur_len   = PKT_LEN_MAP[{rx_func, 4'b0000} +: 16];
  assign last_beat = (beat == cur_len - 16'd1);

  always_ff @(posedge sys_clk_p or posedge sys_reset) begin
    if (sys_reset) begin
      state   <= RX_IDLE;
      beat    <= '0;
      rx_func <= '0;
    end else begin
      state   <= state_next;
      beat    <= beat_next;
      rx_func <= rx_func_next;
    end
  end

  always_comb begin
    state_next   = state;
    beat_next    = beat;
    rx_func_next = rx_func;
    case (state)
      RX_IDLE: begin
        if (i_rx_start && user_lnk_up && (sel_len != 16'd0)) begin
          state_next   = RX_SEND;
          beat_next    = '0;
          rx_func_next = i_rx_func;
        end
      end
      RX_SEND: begin
        if (m_axis_rx_tready) begin
          if (last_beat) begin
            state_next = RX_IDLE;
            beat_next  = '0;
          end else begin
            beat_next = beat + 16'd1;
          end
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign m_axis_rx_tvalid = (state == RX_SEND);
  assign m_axis_rx_tdata  = m_axis_rx_tvalid ? DATA_WIDTH'(beat) : '0;
  assign m_axis_rx_tkeep  = {KW{m_axis_rx_tvalid}};
  assign m_axis_rx_tlast  = m_axis_rx_tvalid && last_beat;

  // Throttle slot closes on the last count of each TX_THROTTLE+1 window.
  logic [31:0] thr_cnt;
  logic        slot_open;

  always_ff @(posedge sys_clk_p or posedge sys_reset) begin
    if (sys_reset)
      thr_cnt <= '0;
    else if (thr_cnt >= 32'(TX_THROTTLE))
      thr_cnt <= '0;
    else
      thr_cnt <= thr_cnt + 32'd1;
  end

  assign slot_open        = (TX_THROTTLE == 0) || (thr_cnt != 32'(TX_THROTTLE));
  assign s_axis_tx_tready = user_lnk_up && slot_open;

  always_ff @(posedge sys_clk_p or posedge sys_reset) begin
    if (sys_reset) begin
      o_tx_beat_count <= '0;
      o_tx_pkt_count  <= '0;
    end else if (s_axis_tx_tvalid && s_axis_tx_tready) begin
      o_tx_beat_count <= o_tx_beat_count + 32'd1;
      if (s_axis_tx_tlast)
        o_tx_pkt_count <= o_tx_pkt_count + 16'd1;
    end
  end

  logic [31:0] cfg_rd_data;

  always_comb begin
    cfg_rd_data = 32'hFFFF_FFFF;
    case (cfg_dwaddr)
      10'd4:                      cfg_rd_data = 32'h0000_0200;
      10'd5:                      cfg_rd_data = 32'h0000_1000;
      10'd6, 10'd7, 10'd8, 10'd9: cfg_rd_data = 32'h0000_0000;
      default:                    cfg_rd_data = 32'hFFFF_FFFF;
    endcase
  end

  always_ff @(posedge sys_clk_p or posedge sys_reset) begin
    if (sys_reset) begin
      cfg_do         <= '0;
      cfg_rd_wr_done <= 1'b0;
    end else begin
      cfg_rd_wr_done <= cfg_rd_en;
      if (cfg_rd_en)
        cfg_do <= cfg_rd_data;
    end
  end

`ifdef SIM_PCIE_INTR_EN
  // 0 = idle, 1 = request seen, 2 = acknowledge cycle; requests outside idle are dropped.
  logic [1:0] intr_cnt;

  always_ff @(posedge sys_clk_p or posedge sys_reset) begin
    if (sys_reset)
      intr_cnt <= 2'd0;
    else begin
      case (intr_cnt)
        2'd0:    intr_cnt <= cfg_interrupt ? 2'd1 : 2'd0;
        2'd1:    intr_cnt <= 2'd2;
        default: intr_cnt <= 2'd0;
      endcase
    end
  end

  assign cfg_interrupt_rdy = (intr_cnt == 2'd2);

  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tx_tdata, s_axis_tx_tkeep};
`else
  assign cfg_interrupt_rdy = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tx_tdata, s_axis_tx_tkeep, cfg_interrupt};
`endif

endmodule

// File: tb/tb_sim_pcie_axis_model.sv
// Scoreboard bench for sim_pcie_axis_model: RX beats and config reads are queued as stimulus is issued
// and checked by a negedge monitor; link sequencing, TX throttle/counters, interrupt and reset are checked inline.
module tb_sim_pcie_axis_model;

  logic        sys_clk_p;
  logic        sys_reset;
  logic        user_reset_out;
  logic        user_lnk_up;
  logic        user_enable_comm;
  logic        i_rx_start;
  logic [2:0]  i_rx_func;
  logic [31:0] m_axis_rx_tdata;
  logic [3:0]  m_axis_rx_tkeep;
  logic        m_axis_rx_tlast;
  logic        m_axis_rx_tvalid;
  logic        m_axis_rx_tready;
  logic [31:0] s_axis_tx_tdata;
  logic [3:0]  s_axis_tx_tkeep;
  logic        s_axis_tx_tlast;
  logic        s_axis_tx_tvalid;
  logic        s_axis_tx_tready;
  logic [31:0] o_tx_beat_count;
  logic [15:0] o_tx_pkt_count;
  logic [9:0]  cfg_dwaddr;
  logic        cfg_rd_en;
  logic [31:0] cfg_do;
  logic        cfg_rd_wr_done;
  logic        cfg_interrupt;
  logic        cfg_interrupt_rdy;

  sim_pcie_axis_model #(
    .DATA_WIDTH   (32),
    .RESET_CYCLES (16),
    .LINKUP_CYCLES(16),
    .TX_THROTTLE  (3)
  ) dut (
    .sys_clk_p        (sys_clk_p),
    .sys_reset        (sys_reset),
    .user_reset_out   (user_reset_out),
    .user_lnk_up      (user_lnk_up),
    .user_enable_comm (user_enable_comm),
    .i_rx_start       (i_rx_start),
    .i_rx_func        (i_rx_func),
    .m_axis_rx_tdata  (m_axis_rx_tdata),
    .m_axis_rx_tkeep  (m_axis_rx_tkeep),
    .m_axis_rx_tlast  (m_axis_rx_tlast),
    .m_axis_rx_tvalid (m_axis_rx_tvalid),
    .m_axis_rx_tready (m_axis_rx_tready),
    .s_axis_tx_tdata  (s_axis_tx_tdata),
    .s_axis_tx_tkeep  (s_axis_tx_tkeep),
    .s_axis_tx_tlast  (s_axis_tx_tlast),
    .s_axis_tx_tvalid (s_axis_tx_tvalid),
    .s_axis_tx_tready (s_axis_tx_tready),
    .o_tx_beat_count  (o_tx_beat_count),
    .o_tx_pkt_count   (o_tx_pkt_count),
    .cfg_dwaddr       (cfg_dwaddr),
    .cfg_rd_en        (cfg_rd_en),
    .cfg_do           (cfg_do),
    .cfg_rd_wr_done   (cfg_rd_wr_done),
    .cfg_interrupt    (cfg_interrupt),
    .cfg_interrupt_rdy(cfg_interrupt_rdy)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } rx_exp_t;

  rx_exp_t     rx_q[$];
  logic [31:0] cfg_q[$];
  int          rx_popped = 0;
  int          compared = 0;
  int          mismatched = 0;

  initial sys_clk_p = 1'b0;
  always #5 sys_clk_p = ~sys_clk_p;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  // Issue one RX start for function f and queue the beats a core would expect back.
  task automatic applyStimulus(input logic [2:0] f, input int exp_len);
    i_rx_start = 1'b1;
    i_rx_func  = f;
    for (int k = 0; k < exp_len; k++)
      rx_q.push_back('{data: 32'(k), last: (k == exp_len - 1)});
    @(posedge sys_clk_p); #1;
    i_rx_start = 1'b0;
  endtask

  task automatic wait_rx_drain(input int budget, input bit toggle);
    int cyc = 0;
    while (rx_q.size() != 0 && cyc < budget) begin
      @(posedge sys_clk_p); #1;
      if (toggle) m_axis_rx_tready = ~m_axis_rx_tready;
      cyc++;
    end
    checkOutput("rx_drain_remaining", 64'(rx_q.size()), 64'd0);
    checkOutput("rx_valid_after_pkt", 64'(m_axis_rx_tvalid), 64'd0);
  endtask

  // Monitor: while tvalid is up the presented beat must match the queue head (also covers stalls).
  always @(negedge sys_clk_p) begin
    if (!sys_reset && m_axis_rx_tvalid) begin
      if (rx_q.size() == 0) begin
        checkOutput("rx_unexpected_valid", 64'(m_axis_rx_tvalid), 64'd0);
      end else begin
        checkOutput("rx_tdata", 64'(m_axis_rx_tdata), 64'(rx_q[0].data));
        checkOutput("rx_tlast", 64'(m_axis_rx_tlast), 64'(rx_q[0].last));
        checkOutput("rx_tkeep", 64'(m_axis_rx_tkeep), 64'hF);
        if (m_axis_rx_tready) begin
          void'(rx_q.pop_front());
          rx_popped++;
        end
      end
    end
    if (!sys_reset && cfg_rd_wr_done) begin
      if (cfg_q.size() == 0)
        checkOutput("cfg_unexpected_done", 64'(cfg_rd_wr_done), 64'd0);
      else
        checkOutput("cfg_do_scoreboard", 64'(cfg_do), 64'(cfg_q.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0]  addrs[4];
    logic [31:0] exps[4];
    logic        tr_samples[$];
    int          pulses;
    int          sent;
    int          cyc;
    int          phase;
    int          base;

    sys_reset        = 1'b1;
    i_rx_start       = 1'b0;
    i_rx_func        = 3'd0;
    m_axis_rx_tready = 1'b1;
    s_axis_tx_tdata  = 32'hA5A5_0000;
    s_axis_tx_tkeep  = 4'hF;
    s_axis_tx_tlast  = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    cfg_dwaddr       = 10'd0;
    cfg_rd_en        = 1'b0;
    cfg_interrupt    = 1'b0;
    #1;
    checkOutput("rst_user_reset", 64'(user_reset_out), 64'd1);
    checkOutput("rst_lnk_up", 64'(user_lnk_up), 64'd0);
    checkOutput("rst_rx_tvalid", 64'(m_axis_rx_tvalid), 64'd0);
    checkOutput("rst_tx_tready", 64'(s_axis_tx_tready), 64'd0);
    checkOutput("rst_cfg_do", 64'(cfg_do), 64'd0);
    checkOutput("rst_beat_count", 64'(o_tx_beat_count), 64'd0);

    // Link bring-up: edge n counts from the first edge after release.
    repeat (3) @(posedge sys_clk_p);
    #1 sys_reset = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge sys_clk_p); #1;
      if (n == 15) checkOutput("user_reset_at_15", 64'(user_reset_out), 64'd1);
      if (n == 16) checkOutput("user_reset_at_16", 64'(user_reset_out), 64'd0);
      if (n == 31) checkOutput("lnk_up_at_31", 64'(user_lnk_up), 64'd0);
      if (n == 32) checkOutput("lnk_up_at_32", 64'(user_lnk_up), 64'd1);
      if (user_enable_comm) begin
        pulses++;
        checkOutput("enable_comm_cycle", 64'(n), 64'd47);
      end
    end
    checkOutput("enable_comm_pulses", 64'(pulses), 64'd1);
    checkOutput("lnk_up_held", 64'(user_lnk_up), 64'd1);

    // RX: function 0 full rate, function 2 empty, function 1 with toggling ready.
    applyStimulus(3'd0, 128);
    wait_rx_drain(400, 1'b0);
    applyStimulus(3'd2, 0);
    repeat (5) @(posedge sys_clk_p);
    #1 checkOutput("rx_f2_no_valid", 64'(m_axis_rx_tvalid), 64'd0);
    applyStimulus(3'd1, 512);
    wait_rx_drain(3000, 1'b1);
    m_axis_rx_tready = 1'b1;

    // TX: 10-beat packet against a throttle that closes one slot in every four.
    sent = 0;
    cyc  = 0;
    s_axis_tx_tvalid = 1'b1;
    while (sent < 10 && cyc < 60) begin
      s_axis_tx_tlast = (sent == 9);
      s_axis_tx_tdata = 32'hA5A5_0000 + 32'(sent);
      @(negedge sys_clk_p);
      tr_samples.push_back(s_axis_tx_tready);
      if (s_axis_tx_tready) sent++;
      @(posedge sys_clk_p); #1;
      cyc++;
    end
    s_axis_tx_tvalid = 1'b0;
    s_axis_tx_tlast  = 1'b0;
    checkOutput("tx_beats_sent", 64'(sent), 64'd10);
    phase = -1;
    for (int i = 0; i < 4 && i < tr_samples.size(); i++)
      if (phase < 0 && !tr_samples[i]) phase = i;
    checkOutput("tx_throttle_low_found", 64'(phase >= 0), 64'd1);
    if (phase < 0) phase = 0;
    for (int i = 0; i < tr_samples.size(); i++)
      checkOutput("tx_tready_pattern", 64'(tr_samples[i]), 64'(((i + 4 - phase) % 4) != 0));
    checkOutput("tx_beat_count", 64'(o_tx_beat_count), 64'd10);
    checkOutput("tx_pkt_count", 64'(o_tx_pkt_count), 64'd1);

    // Config reads, back to back; last address is out of range so its all-ones value must hold.
    addrs = '{10'd5, 10'd4, 10'd7, 10'd12};
    exps  = '{32'h0000_1000, 32'h0000_0200, 32'h0000_0000, 32'hFFFF_FFFF};
    cfg_rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_dwaddr = addrs[i];
      cfg_q.push_back(exps[i]);
      @(posedge sys_clk_p); #1;
      checkOutput("cfg_done_next_cycle", 64'(cfg_rd_wr_done), 64'd1);
      checkOutput("cfg_do_next_cycle", 64'(cfg_do), 64'(exps[i]));
    end
    cfg_rd_en  = 1'b0;
    cfg_dwaddr = 10'd5;
    repeat (2) @(posedge sys_clk_p);
    #1;
    checkOutput("cfg_done_clear", 64'(cfg_rd_wr_done), 64'd0);
    checkOutput("cfg_do_hold", 64'(cfg_do), 64'hFFFF_FFFF);
    checkOutput("cfg_queue_empty", 64'(cfg_q.size()), 64'd0);

`ifdef SIM_PCIE_INTR_EN
    cfg_interrupt = 1'b1;
    @(posedge sys_clk_p); #1;
    checkOutput("intr_rdy_early", 64'(cfg_interrupt_rdy), 64'd0);
    @(posedge sys_clk_p); #1;
    checkOutput("intr_rdy", 64'(cfg_interrupt_rdy), 64'd1);
    cfg_interrupt = 1'b0;
    @(posedge sys_clk_p); #1;
    checkOutput("intr_rdy_single", 64'(cfg_interrupt_rdy), 64'd0);
`else
    cfg_interrupt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge sys_clk_p); #1;
      checkOutput("intr_rdy_disabled", 64'(cfg_interrupt_rdy), 64'd0);
    end
    cfg_interrupt = 1'b0;
`endif

    // Reset in the middle of a function-1 packet, then relink and restart from beat 0.
    applyStimulus(3'd1, 512);
    base = rx_popped;
    cyc  = 0;
    while (rx_popped < base + 50 && cyc < 200) begin
      @(posedge sys_clk_p); #1;
      cyc++;
    end
    checkOutput("rx_valid_before_reset", 64'(m_axis_rx_tvalid), 64'd1);
    checkOutput("rx_beat50_data", 64'(m_axis_rx_tdata), 64'd50);
    #1 sys_reset = 1'b1;
    #1;
    rx_q.delete();
    checkOutput("abort_tvalid", 64'(m_axis_rx_tvalid), 64'd0);
    checkOutput("abort_tlast", 64'(m_axis_rx_tlast), 64'd0);
    checkOutput("abort_user_reset", 64'(user_reset_out), 64'd1);
    checkOutput("abort_lnk_up", 64'(user_lnk_up), 64'd0);
    checkOutput("abort_beat_count", 64'(o_tx_beat_count), 64'd0);
    checkOutput("abort_pkt_count", 64'(o_tx_pkt_count), 64'd0);
    checkOutput("abort_cfg_do", 64'(cfg_do), 64'd0);
    repeat (3) @(posedge sys_clk_p);
    #1 sys_reset = 1'b0;
    cyc = 0;
    while (!user_lnk_up && cyc < 100) begin
      @(posedge sys_clk_p); #1;
      cyc++;
    end
    checkOutput("relink", 64'(user_lnk_up), 64'd1);
    checkOutput("no_resume_after_reset", 64'(m_axis_rx_tvalid), 64'd0);
    applyStimulus(3'd0, 128);
    checkOutput("restart_first_data", 64'(m_axis_rx_tdata), 64'd0);
    wait_rx_drain(400, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
